// File: rtl/iluminacao_pkg.sv
// Shared types and default timing constants for the multi-zone lighting controller.
// All durations are expressed in 1 ms ticks.
package iluminacao_pkg;

    typedef enum logic [1:0] {
        DESL_AUTO = 2'd0,
        LIG_AUTO  = 2'd1,
        LIG_MAN   = 2'd2,
        DESL_MAN  = 2'd3
    } estado_zona_t;

    localparam int unsigned N_ZONAS_DEF       = 4;
    localparam int unsigned T_DEBOUNCE_MS_DEF = 300;
    localparam int unsigned T_LONGO_MS_DEF    = 5000;
    localparam int unsigned T_APAGA_MS_DEF    = 30000;
    localparam int unsigned W_CNT_DEF         = 16;

endpackage

// File: rtl/iluminacao_zona.sv
// One lighting zone: press-duration classifier, presence off-delay timer and
// the four-state auto/manual FSM. Outputs decode the state register directly.
module iluminacao_zona
    import iluminacao_pkg::*;
#(
    parameter int unsigned T_DEBOUNCE_MS = T_DEBOUNCE_MS_DEF,
    parameter int unsigned T_LONGO_MS    = T_LONGO_MS_DEF,
    parameter int unsigned T_APAGA_MS    = T_APAGA_MS_DEF,
    parameter int unsigned W_CNT         = W_CNT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_ms,
    input  logic botao,
    input  logic infra,
    input  logic forca_auto,
    output logic lampada,
    output logic led_manual,
    output logic timer_ativo,
    output logic evento_longo
);

    localparam logic [W_CNT-1:0] TD    = W_CNT'(T_DEBOUNCE_MS);
    localparam logic [W_CNT-1:0] TL    = W_CNT'(T_LONGO_MS);
    localparam logic [W_CNT-1:0] TL_M1 = W_CNT'(T_LONGO_MS - 1);
    localparam logic [W_CNT-1:0] TA_M1 = W_CNT'(T_APAGA_MS - 1);

    estado_zona_t     estado, prox;
    logic [W_CNT-1:0] tp, tc;
    logic             botao_d, longo_feito;
    logic             soltou, ev_l, ev_s, ev_c;

    always_comb begin
        soltou = botao_d & ~botao;
        ev_l   = tick_ms & botao & (tp == TL_M1) & ~longo_feito;
        ev_s   = soltou & (tp > TD) & (tp < TL);
        ev_c   = (estado == LIG_AUTO) & tick_ms & ~infra & (tc == TA_M1);
    end

    // forca_auto swallows any press event of the same cycle
    always_comb begin
        prox = estado;
        if (forca_auto) begin
            prox = DESL_AUTO;
        end else begin
            unique case (estado)
                DESL_AUTO: begin
                    if (ev_l)       prox = DESL_MAN;
                    else if (infra) prox = LIG_AUTO;
                end
                LIG_AUTO: begin
                    if (ev_l)      prox = DESL_MAN;
                    else if (ev_c) prox = DESL_AUTO;
                end
                LIG_MAN: begin
                    if (ev_l)      prox = LIG_AUTO;
                    else if (ev_s) prox = DESL_MAN;
                end
                DESL_MAN: begin
                    if (ev_l)      prox = LIG_AUTO;
                    else if (ev_s) prox = LIG_MAN;
                end
                default: prox = DESL_AUTO;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado       <= DESL_AUTO;
            tp           <= '0;
            tc           <= '0;
            botao_d      <= 1'b0;
            longo_feito  <= 1'b0;
            evento_longo <= 1'b0;
        end else begin
            estado       <= prox;
            botao_d      <= botao;
            evento_longo <= ev_l & ~forca_auto;

            if (soltou) begin
                tp          <= '0;
                longo_feito <= 1'b0;
            end else begin
                if (tick_ms && botao && (tp != TL))
                    tp <= tp + 1'b1;
                if (ev_l)
                    longo_feito <= 1'b1;
            end

            if ((estado != LIG_AUTO) || infra || (prox != estado))
                tc <= '0;
            else if (tick_ms)
                tc <= tc + 1'b1;
        end
    end

    always_comb begin
        lampada     = (estado == LIG_AUTO) || (estado == LIG_MAN);
        led_manual  = (estado == LIG_MAN)  || (estado == DESL_MAN);
        timer_ativo = (estado == LIG_AUTO);
    end

endmodule

// File: rtl/iluminacao_multizona.sv
// N-zone automatic/manual lighting controller; tick_ms, forca_auto and rst
// are shared, every zone otherwise runs independently.
module iluminacao_multizona
    import iluminacao_pkg::*;
#(
    parameter int unsigned N_ZONAS       = N_ZONAS_DEF,
    parameter int unsigned T_DEBOUNCE_MS = T_DEBOUNCE_MS_DEF,
    parameter int unsigned T_LONGO_MS    = T_LONGO_MS_DEF,
    parameter int unsigned T_APAGA_MS    = T_APAGA_MS_DEF,
    parameter int unsigned W_CNT         = W_CNT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_ms,
    input  logic [N_ZONAS-1:0] botao,
    input  logic [N_ZONAS-1:0] infra,
    input  logic               forca_auto,
    output logic [N_ZONAS-1:0] lampada,
    output logic [N_ZONAS-1:0] led_manual,
    output logic [N_ZONAS-1:0] timer_ativo,
    output logic [N_ZONAS-1:0] evento_longo
);

    for (genvar z = 0; z < N_ZONAS; z++) begin : g_zona
        iluminacao_zona #(
            .T_DEBOUNCE_MS(T_DEBOUNCE_MS),
            .T_LONGO_MS   (T_LONGO_MS),
            .T_APAGA_MS   (T_APAGA_MS),
            .W_CNT        (W_CNT)
        ) u_zona (
            .clk         (clk),
            .rst         (rst),
            .tick_ms     (tick_ms),
            .botao       (botao[z]),
            .infra       (infra[z]),
            .forca_auto  (forca_auto),
            .lampada     (lampada[z]),
            .led_manual  (led_manual[z]),
            .timer_ativo (timer_ativo[z]),
            .evento_longo(evento_longo[z])
        );
    end

endmodule
